// File: rtl/keystone_output_fifo.sv
// Elastic first-word-fall-through output buffer between keystone correction and the AXI video
// master. Registers ready toward the upstream stage and checks line length on accepted beats.
module keystone_output_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int LINE_WIDTH = 640
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clock_en,
    input  logic [DATA_WIDTH-1:0]      pixel_stream_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic                       start_of_frame_in,
    input  logic                       end_of_line_in,
    output logic [DATA_WIDTH-1:0]      pixel_stream_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       start_of_frame_out,
    output logic                       end_of_line_out,
    output logic [$clog2(DEPTH):0]     fill_level,
    input  logic                       clear_errors,
    output logic                       eol_error,
    output logic                       sof_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);

    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  next_count;
    logic [XW-1:0]  x_pos;
    logic [XW-1:0]  x_eff;
    logic [XW-1:0]  x_next;
    logic           push;
    logic           pop;
    logic           eol_set;
    logic           sof_set;
    entry_t         head;

    assign push = clock_en & valid_in & ready_out;
    assign pop  = clock_en & valid_out & ready_in;

    assign head               = mem[rd_ptr];
    assign pixel_stream_out   = head.data;
    assign start_of_frame_out = head.sof;
    assign end_of_line_out    = head.eol;
    assign fill_level         = count;

    always_comb begin
        next_count = count;
        unique case ({push, pop})
            2'b10:   next_count = count + CW'(1);
            2'b01:   next_count = count - CW'(1);
            default: next_count = count;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and count decide what is valid, and
    // leaving it out of the reset keeps it a plain register file.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{sof: start_of_frame_in, eol: end_of_line_in, data: pixel_stream_in};
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all state advances together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            ready_out <= 1'b0;
        end else if (clock_en) begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= next_count;
            valid_out <= (next_count != '0);
            ready_out <= (next_count < CW'(DEPTH));
        end
    end

    // Line checker: a SOF beat is always taken as x=0; any mismatch resynchronises to a new line.
    // NOTE: all outputs of this block get a default first so no latch is inferred.
    always_comb begin
        x_eff   = start_of_frame_in ? '0 : x_pos;
        sof_set = push & start_of_frame_in & (x_pos != '0);
        eol_set = 1'b0;
        x_next  = x_pos;
        if (push) begin
            if (end_of_line_in) begin
                eol_set = (x_eff != X_LAST);
                x_next  = '0;
            end else if (x_eff == X_LAST) begin
                eol_set = 1'b1;
                x_next  = '0;
            end else begin
                x_next  = x_eff + XW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_pos <= '0;
        end else if (clock_en) begin
            x_pos <= x_next;
        end
    end

    // Sticky flags: clear ignores clock_en, and a new error in the same cycle beats the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eol_error <= 1'b0;
            sof_error <= 1'b0;
        end else begin
            eol_error <= eol_set | (eol_error & ~clear_errors);
            sof_error <= sof_set | (sof_error & ~clear_errors);
        end
    end

endmodule
